// File: rtl/user_pkg.sv
// User-domain shared definitions: OBI subordinate types, demux map and
// the register offsets of the user interrupt controller.
package user_pkg;

    localparam int unsigned ObiIdWidth = 4;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [ObiIdWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]           rdata;
        logic [ObiIdWidth-1:0] rid;
        logic                  err;
        logic                  r_optional;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    // Demux port 0 is the error subordinate that catches unmapped accesses.
    typedef enum int unsigned {
        UserError   = 0,
        UserIrqCtrl = 1
    } user_demux_outputs_e;

    localparam int unsigned NumDemuxSbr      = 2;
    localparam int unsigned NumDemuxSbrRules = 1;

    typedef struct packed {
        int unsigned idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam logic [31:0] UserBaseAddr          = 32'h2000_0000;
    localparam logic [31:0] UserIrqCtrlAddrOffset = 32'h0000_0000;
    localparam logic [31:0] UserIrqCtrlAddrRange  = 32'h0000_1000;

    localparam addr_map_rule_t UserIrqCtrlRule = '{
        idx:        int'(UserIrqCtrl),
        start_addr: UserBaseAddr + UserIrqCtrlAddrOffset,
        end_addr:   UserBaseAddr + UserIrqCtrlAddrOffset + UserIrqCtrlAddrRange
    };

    localparam addr_map_rule_t user_addr_map [NumDemuxSbrRules] = '{UserIrqCtrlRule};

    localparam logic [31:0] IrqIeOffset   = 32'h0;
    localparam logic [31:0] IrqPendOffset = 32'h4;
    localparam logic [31:0] IrqModeOffset = 32'h8;
    localparam logic [31:0] IrqCntOffset  = 32'hC;

endpackage

// File: rtl/user_irq_debounce.sv
// Single-bit debounce filter: the output follows the input only after it has
// differed from the output for DebounceCycles consecutive samples.
module user_irq_debounce #(
    parameter int unsigned DebounceCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw,
    output logic filtered
);

    if (DebounceCycles == 0) begin : g_bypass
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                filtered <= 1'b0;
            end else begin
                filtered <= raw;
            end
        end
    end else begin : g_filter
        localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
        localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

        logic [CntW-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q    <= '0;
                filtered <= 1'b0;
            end else if (raw == filtered) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                cnt_q    <= '0;
                filtered <= raw;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/user_irq_ctrl.sv
// OBI-attached interrupt controller: debounced sources latch into pending
// bits, masked by IE onto a single registered-path interrupt line.
module user_irq_ctrl
    import user_pkg::*;
#(
    parameter int unsigned NumSrc         = 1,
    parameter int unsigned DebounceCycles = 4,
    parameter int unsigned CntWidth       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  sbr_obi_req_t      obi_req_i,
    output sbr_obi_rsp_t      obi_rsp_o,
    input  logic [NumSrc-1:0] irq_src_i,
    output logic              irq_o
);

    logic [NumSrc-1:0]     filt, filt_q, set;
    logic [NumSrc-1:0]     ie_q, ie_d, mode_q, mode_d, pend_q, pend_d, w1c_mask;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  rvalid_q;
    logic [ObiIdWidth-1:0] rid_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            reg_sel;
    logic                  wr_en, rd_en, cnt_clr, cnt_inc;
    logic                  unused_obi;

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        user_irq_debounce #(
            .DebounceCycles(DebounceCycles)
        ) u_debounce (
            .clk_i,
            .rst_ni,
            .raw      (irq_src_i[i]),
            .filtered (filt[i])
        );
    end

    // Edge mode fires once on a filtered rise; level mode fires every high cycle.
    assign set = (mode_q & filt & ~filt_q) | (~mode_q & filt);

    assign unused_obi = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0],
                          obi_req_i.a.be[3:1], obi_req_i.a.wdata[31:NumSrc]};

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can infer a latch.
    always_comb begin
        reg_sel  = obi_req_i.a.addr[3:2];
        wr_en    = obi_req_i.req & obi_req_i.a.we & obi_req_i.a.be[0];
        rd_en    = obi_req_i.req & ~obi_req_i.a.we;
        ie_d     = ie_q;
        mode_d   = mode_q;
        w1c_mask = '0;
        cnt_clr  = 1'b0;
        rdata_d  = '0;

        if (wr_en) begin
            case (reg_sel)
                IrqIeOffset[3:2]:   ie_d     = obi_req_i.a.wdata[NumSrc-1:0];
                IrqPendOffset[3:2]: w1c_mask = obi_req_i.a.wdata[NumSrc-1:0];
                IrqModeOffset[3:2]: mode_d   = obi_req_i.a.wdata[NumSrc-1:0];
                default:            cnt_clr  = 1'b1;
            endcase
        end

        if (rd_en) begin
            case (reg_sel)
                IrqIeOffset[3:2]:   rdata_d[NumSrc-1:0]   = ie_q;
                IrqPendOffset[3:2]: rdata_d[NumSrc-1:0]   = pend_q;
                IrqModeOffset[3:2]: rdata_d[NumSrc-1:0]   = mode_q;
                default:            rdata_d[CntWidth-1:0] = cnt_q;
            endcase
        end

        // A new event outranks a software clear of the same bit.
        pend_d = (pend_q & ~w1c_mask) | set;

        cnt_inc = |(set & ie_q);
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q     <= '0;
            mode_q   <= '1;
            pend_q   <= '0;
            cnt_q    <= '0;
            filt_q   <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            ie_q     <= ie_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt;
            rvalid_q <= obi_req_i.req;
            rdata_q  <= rdata_d;
            if (obi_req_i.req) begin
                rid_q <= obi_req_i.a.aid;
            end
        end
    end

    always_comb begin
        obi_rsp_o              = '0;
        obi_rsp_o.gnt          = obi_req_i.req;
        obi_rsp_o.rvalid       = rvalid_q;
        obi_rsp_o.r.rdata      = rdata_q;
        obi_rsp_o.r.rid        = rid_q;
        obi_rsp_o.r.err        = 1'b0;
        obi_rsp_o.r.r_optional = 1'b0;
    end

    assign irq_o = |(pend_q & ie_q);

endmodule
